// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx serializer between NUM_REQ byte sources,
// with per-requester lock for atomic messages and a WAIT watchdog for a missing TX_Done.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int TIMEOUT_CLKS = 16384
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_byte,
  input  logic [NUM_REQ-1:0]   i_req_lock,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [7:0]           o_tx_byte,
  output logic                 o_tx_dv,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_timeout
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, GAP} state_t;
  state_t state, state_d;
  logic [PW-1:0] rr_ptr, rr_d, lock_id, lock_id_d, win, sel;
  logic lock_vld, lock_vld_d, found, go;
  logic [CW-1:0] cnt, cnt_d;
  logic [NUM_REQ-1:0] ready_d, grant_d;
  logic [7:0] byte_d;
  logic dv_d, timeout_d;
  // first valid requester after the last winner
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && i_req_valid[PW'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        found = 1'b1;
        win = PW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
  always_comb begin
    state_d = state;
    rr_d = rr_ptr;
    lock_id_d = lock_id;
    lock_vld_d = lock_vld;
    cnt_d = cnt;
    ready_d = '0;
    grant_d = o_grant;
    byte_d = o_tx_byte;
    dv_d = 1'b0;
    timeout_d = 1'b0;
    sel = win;
    go = 1'b0;
    case (state)
      IDLE: begin
        if (lock_vld && i_req_valid[lock_id]) begin
          sel = lock_id;
          go = 1'b1;
        end else if (!(lock_vld && i_req_lock[lock_id])) begin
          lock_vld_d = 1'b0;
          go = found;
        end
        if (go) begin
          state_d = GRANT;
          byte_d = i_req_byte[{sel, 3'b000} +: 8];
          ready_d[sel] = 1'b1;
          grant_d = ready_d;
          rr_d = sel;
          lock_id_d = sel;
          lock_vld_d = i_req_lock[sel];
        end
      end
      GRANT: begin
        state_d = SEND;
        dv_d = !i_tx_active;
      end
      SEND: begin
        state_d = o_tx_dv ? WAIT : SEND;
        dv_d = !o_tx_dv && !i_tx_active;
      end
      WAIT: begin
        cnt_d = cnt + 1'b1;
        if (i_tx_done) state_d = GAP;
        else if (cnt == CW'(TIMEOUT_CLKS - 1)) begin
          state_d = GAP;
          timeout_d = 1'b1;
          lock_vld_d = 1'b0;
        end
      end
      GAP: begin
        state_d = IDLE;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= PW'(NUM_REQ - 1);
      lock_id <= '0;
      lock_vld <= 1'b0;
      cnt <= '0;
      o_req_ready <= '0;
      o_grant <= '0;
      o_tx_byte <= '0;
      o_tx_dv <= 1'b0;
      o_busy <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state <= state_d;
      rr_ptr <= rr_d;
      lock_id <= lock_id_d;
      lock_vld <= lock_vld_d;
      cnt <= cnt_d;
      o_req_ready <= ready_d;
      o_grant <= grant_d;
      o_tx_byte <= byte_d;
      o_tx_dv <= dv_d;
      o_busy <= state_d != IDLE;
      o_timeout <= timeout_d;
    end
  end
endmodule
